// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX serializer and its helpers.
// Build macro UART_TX_PARITY_EN (set on the consuming design) selects 8E1 framing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int DATA_BITS        = 8;
  localparam int DEFAULT_CLK_FREQ = 50000000;
  localparam int DEFAULT_BAUD     = 115200;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// Held at zero while i_clear is high so a new frame starts on a fresh bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-wide 8N1 UART transmitter with registered outputs; tx_busy paces the byte producer.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop (8E1).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_serial,
  output logic       tx_done
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
`endif
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic [2:0] r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_busy;
  logic       r_serial;
  logic       r_done;
`ifdef UART_TX_PARITY_EN
  logic       r_parity;
`endif

  logic       w_tick;
  logic       w_clear;

  // Counter is parked at zero in IDLE so the start bit gets a full period.
  assign w_clear = (r_state == ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_clear),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_busy    <= 1'b0;
      r_serial  <= 1'b1;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_start) begin
            r_shift   <= tx_data;
            r_bit_idx <= '0;
            r_busy    <= 1'b1;
            r_serial  <= 1'b0;
            r_state   <= ST_START;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^tx_data;
`endif
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_serial <= r_shift[0];
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_serial <= r_parity;
              r_state  <= ST_PARITY;
`else
              r_serial <= 1'b1;
              r_state  <= ST_STOP;
`endif
            end else begin
              // Next bit is shift[1] now, which becomes shift[0] after this edge.
              r_serial <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_serial <= 1'b1;
            r_state  <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_busy   = r_busy;
  assign tx_serial = r_serial;
  assign tx_done   = r_done;

endmodule
